// File: rtl/bitorder_rr_scheduler_pkg.sv
// Shared definitions for the bit-order round-robin scheduler: output-stage
// state encoding, default word width and a width helper.
package bitorder_rr_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bitorder_rr_scheduler_bitrev_unit.sv
// Combinational bit-order converter: passes a word through or maps bit k
// to bit DATA_W-1-k.
module bitrev_unit
    import bitorder_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] in_word,
    input  logic              reverse,
    output logic [DATA_W-1:0] out_word
);

    always_comb begin
        out_word = in_word;
        if (reverse) begin
            for (int k = 0; k < DATA_W; k++) begin
                out_word[k] = in_word[DATA_W-1-k];
            end
        end
    end

endmodule

// File: rtl/bitorder_rr_scheduler.sv
// Round-robin scheduler sharing one bit-order converter between NUM_REQ
// requesters, with a one-entry registered output stage.
module bitorder_rr_scheduler
    import bitorder_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int SRC_W   = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_reverse,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      busy
);

    // Handshakes: a word moves across an interface on a rising edge where
    // valid and ready are both high. The producer holds its word stable
    // while valid is high and ready is low; ready never depends on a
    // requester that is not valid, and out_data is frozen while
    // out_valid=1 and out_ready=0.

    state_t            state;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  next_ptr;
    logic [SRC_W:0]    idx_w;
    logic              found;
    logic              any_valid;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic              sel_rev;
    logic [DATA_W-1:0] conv_data;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx_w = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (idx_w >= (SRC_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (SRC_W+1)'(NUM_REQ);
            end
            if (!found && req_valid[idx_w[SRC_W-1:0]]) begin
                grant = idx_w[SRC_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        any_valid  = |req_valid;
        can_accept = (state == IDLE) || (out_ready && (state == HOLD));
        accept     = !reset && can_accept && any_valid;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (grant == SRC_W'(i));
        end
    end

    // Grant mux ahead of the single shared converter.
    always_comb begin
        sel_data = '0;
        sel_rev  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_rev  = req_reverse[i];
            end
        end
    end

    bitrev_unit #(
        .DATA_W (DATA_W)
    ) u_bitrev (
        .in_word  (sel_data),
        .reverse  (sel_rev),
        .out_word (conv_data)
    );

    assign next_ptr = (grant == SRC_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_data  <= conv_data;
            out_src   <= grant;
            rr_ptr    <= next_ptr;
        end else if ((state == HOLD) && out_ready) begin
            // Drained with nothing to refill: keep the last word visible.
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

    assign busy = out_valid;

endmodule

// File: tb/tb_bitorder_rr_scheduler.sv
// Self-checking bench for bitorder_rr_scheduler: hand-derived vector table,
// directed reset-in-HOLD sequence and a constrained-random scoreboard phase.
module tb_bitorder_rr_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int SRC_W   = 1;
    localparam int W       = SRC_W + DATA_W;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_reverse;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      busy;

    bitorder_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .SRC_W   (SRC_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_reverse (req_reverse),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference model state
    logic [W-1:0]      exp_q[$];
    logic              m_valid     = 1'b0;
    logic [DATA_W-1:0] m_last_data = '0;
    logic [SRC_W-1:0]  m_last_src  = '0;
    int                m_ptr       = 0;
    int                m_gnt       = -1;
    int                n_cmp       = 0;
    int                n_err       = 0;

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] rv;
        logic       ordy;
        logic [1:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic       os;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [DATA_W-1:0] ref_bitrev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W; k++) r[DATA_W-1-k] = w[k];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one clock cycle. Inputs are applied just after the rising
    // edge, outputs are checked on the falling edge, then the model steps.
    task automatic cycle(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] rv, input logic ordy, input bit hand,
                         input logic [1:0] e_rdy, input logic e_ov,
                         input logic [7:0] e_od, input logic e_os);
        logic [1:0]        m_rdy;
        logic [DATA_W-1:0] wd;
        logic [W-1:0]      ent;
        int                g;
        int                idx;
        req_valid   = v;
        req_data    = {d1, d0};
        req_reverse = rv;
        out_ready   = ordy;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && v[idx]) g = idx;
        end
        m_rdy = '0;
        if (!reset && g >= 0 && (!m_valid || ordy)) m_rdy[g] = 1'b1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_last_data));
        chk("out_src", 32'(out_src), 32'(m_last_src));
        chk("req_ready", 32'(req_ready), 32'(m_rdy));
        if (hand) begin
            chk("tbl_ready", 32'(req_ready), 32'(e_rdy));
            chk("tbl_valid", 32'(out_valid), 32'(e_ov));
            chk("tbl_data", 32'(out_data), 32'(e_od));
            chk("tbl_src", 32'(out_src), 32'(e_os));
        end
        if (!reset && m_valid && ordy) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(1), 32'(0));
            end else begin
                ent = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(ent[DATA_W-1:0]));
                chk("sb_src", 32'(out_src), 32'(ent[W-1:DATA_W]));
            end
        end
        m_gnt = -1;
        if (reset) begin
            m_valid     = 1'b0;
            m_last_data = '0;
            m_last_src  = '0;
            m_ptr       = 0;
            exp_q.delete();
        end else if (m_rdy != 2'b00) begin
            wd = (g == 0) ? d0 : d1;
            if (rv[g]) wd = ref_bitrev(wd);
            ent = {SRC_W'(g), wd};
            exp_q.push_back(ent);
            m_valid     = 1'b1;
            m_last_data = wd;
            m_last_src  = SRC_W'(g);
            m_ptr       = (g + 1) % NUM_REQ;
            m_gnt       = g;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [1:0] cv;
    logic [7:0] cd0, cd1;
    logic [1:0] cr;

    initial begin
        // Expected values derived by hand; ov/od/os are what the output stage
        // shows during that row, i.e. the result of earlier rows.
        //            v      d0     d1     rv     rdy_o  exp_rdy ov    od     os
        tbl[0]  = '{2'b01, 8'hC1, 8'h00, 2'b01, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{2'b10, 8'h00, 8'hA5, 2'b00, 1'b1, 2'b10, 1'b1, 8'h83, 1'b0};
        tbl[2]  = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b1, 8'hA5, 1'b1};
        tbl[3]  = '{2'b11, 8'h01, 8'hFF, 2'b11, 1'b1, 2'b01, 1'b0, 8'hA5, 1'b1};
        tbl[4]  = '{2'b11, 8'h00, 8'hFF, 2'b11, 1'b1, 2'b10, 1'b1, 8'h80, 1'b0};
        tbl[5]  = '{2'b11, 8'h00, 8'hFF, 2'b11, 1'b1, 2'b01, 1'b1, 8'hFF, 1'b1};
        tbl[6]  = '{2'b11, 8'h00, 8'hFF, 2'b10, 1'b1, 2'b10, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{2'b11, 8'h00, 8'h12, 2'b10, 1'b1, 2'b01, 1'b1, 8'hFF, 1'b1};
        tbl[8]  = '{2'b11, 8'h3C, 8'h12, 2'b10, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0};
        tbl[9]  = '{2'b11, 8'h3C, 8'h12, 2'b10, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{2'b11, 8'h3C, 8'h12, 2'b10, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0};
        tbl[11] = '{2'b11, 8'h3C, 8'h12, 2'b10, 1'b1, 2'b10, 1'b1, 8'h00, 1'b0};
        tbl[12] = '{2'b01, 8'h3C, 8'h00, 2'b00, 1'b1, 2'b01, 1'b1, 8'h48, 1'b1};
        tbl[13] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b1, 8'h3C, 1'b0};
        tbl[14] = '{2'b10, 8'h00, 8'h00, 2'b10, 1'b1, 2'b10, 1'b0, 8'h3C, 1'b0};
        tbl[15] = '{2'b10, 8'h00, 8'hFF, 2'b00, 1'b1, 2'b10, 1'b1, 8'h00, 1'b1};
        tbl[16] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b1, 8'hFF, 1'b1};

        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_reverse = '0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        // Reset held: outputs cleared and no grant even with both valid.
        cycle(2'b11, 8'h11, 8'h22, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].rv, tbl[i].ordy, 1'b1,
                  tbl[i].rdy, tbl[i].ov, tbl[i].od, tbl[i].os);
        end

        // Reset while HOLD under backpressure: word discarded, pointer back to 0.
        cycle(2'b01, 8'h0F, 8'h00, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 8'hFF, 1'b1);
        reset = 1'b1;
        cycle(2'b11, 8'hAA, 8'h55, 2'b00, 1'b0, 1'b1, 2'b00, 1'b1, 8'h0F, 1'b0);
        reset = 1'b0;
        cycle(2'b11, 8'hAA, 8'h55, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0);
        cycle(2'b10, 8'h00, 8'h55, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 8'hAA, 1'b0);
        cycle(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'h55, 1'b1);

        // Random traffic; a word not yet accepted stays stable.
        cv  = '0;
        cd0 = '0;
        cd1 = '0;
        cr  = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cv[0] || m_gnt == 0) begin
                cv[0] = ($urandom_range(0, 3) != 0);
                cd0   = 8'($urandom_range(0, 255));
                cr[0] = 1'($urandom_range(0, 1));
            end
            if (!cv[1] || m_gnt == 1) begin
                cv[1] = ($urandom_range(0, 3) != 0);
                cd1   = 8'($urandom_range(0, 255));
                cr[1] = 1'($urandom_range(0, 1));
            end
            cycle(cv, cd0, cd1, cr, ($urandom_range(0, 3) != 0), 1'b0,
                  2'b00, 1'b0, 8'h00, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
